// File: rtl/ftdi_sync_rx.sv
// FT232H synchronous FIFO receive engine: RXF#/OE#/RD# handshake into a
// first-word-fall-through byte FIFO with a valid/ready output stream.
module ftdi_sync_rx #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     ftdiclk,
    input  logic                     reset,
    input  logic                     ftdi_rxf_n,
    input  logic [7:0]               ftdi_data_in,
    output logic                     ftdi_oe_n,
    output logic                     ftdi_rd_n,
    input  logic                     rx_enable,
    output logic                     rx_active,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        READ = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            oe_n_next;
    logic            rd_n_next;
    logic            push;
    logic            pop;
    logic            has_space;
    logic            start_ok;
    logic [CW-1:0]   count_next;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [DEPTH];

    // A byte moves only when the strobe we drove and the chip's RXF# are both low.
    assign push       = !ftdi_rd_n && !ftdi_rxf_n;
    assign pop        = m_valid && m_ready;
    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign has_space  = count_next <= CW'(DEPTH - 1);
    assign start_ok   = rx_enable && !ftdi_rxf_n && has_space;

    always_comb begin
        state_next = state;
        oe_n_next  = 1'b1;
        rd_n_next  = 1'b1;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = TURN;
                    oe_n_next  = 1'b0;
                end
            end
            TURN: begin
                if (start_ok) begin
                    state_next = READ;
                    oe_n_next  = 1'b0;
                    rd_n_next  = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                oe_n_next = 1'b0;
                rd_n_next = 1'b0;
                if (ftdi_rxf_n || !rx_enable || count_next == CW'(DEPTH)) begin
                    state_next = IDLE;
                    oe_n_next  = 1'b1;
                    rd_n_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ftdiclk) begin
        if (reset) begin
            state     <= IDLE;
            ftdi_oe_n <= 1'b1;
            ftdi_rd_n <= 1'b1;
            rx_active <= 1'b0;
        end else begin
            state     <= state_next;
            ftdi_oe_n <= oe_n_next;
            ftdi_rd_n <= rd_n_next;
            rx_active <= state_next != IDLE;
        end
    end

    // FIFO bookkeeping; reset discards buffered bytes and any byte on the reset edge.
    always_ff @(posedge ftdiclk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            m_valid    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_next;
            m_valid    <= count_next != '0;
        end
    end

    always_ff @(posedge ftdiclk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= ftdi_data_in;
        end
    end

    assign m_data = mem[rd_ptr];

endmodule

// File: tb/tb_ftdi_sync_rx.sv
// Directed bench for ftdi_sync_rx: a simple FT232H byte source and a consumer
// that logs delivered bytes, checked against hand-computed sequences.
module tb_ftdi_sync_rx;

    logic       ftdiclk;
    logic       reset;
    logic       ftdi_rxf_n;
    logic [7:0] ftdi_data_in;
    logic       ftdi_oe_n;
    logic       ftdi_rd_n;
    logic       rx_enable;
    logic       rx_active;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] fifo_count;

    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] src [0:31];
    int         src_len = 0;
    int         src_idx = 0;
    bit         gap = 1'b0;
    logic [7:0] got [$];

    ftdi_sync_rx #(.DEPTH(8)) dut (
        .ftdiclk      (ftdiclk),
        .reset        (reset),
        .ftdi_rxf_n   (ftdi_rxf_n),
        .ftdi_data_in (ftdi_data_in),
        .ftdi_oe_n    (ftdi_oe_n),
        .ftdi_rd_n    (ftdi_rd_n),
        .rx_enable    (rx_enable),
        .rx_active    (rx_active),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .fifo_count   (fifo_count)
    );

    initial begin
        ftdiclk = 1'b0;
        forever #5 ftdiclk = ~ftdiclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        ftdi_rxf_n   = gap || (src_idx >= src_len);
        ftdi_data_in = (src_idx < src_len) ? src[src_idx] : 8'h00;
    endtask

    // One clock: the chip consumes a byte when RD# and RXF# were low at the edge.
    task automatic tick();
        bit         xfer;
        bit         take;
        logic [7:0] d;
        xfer = !ftdi_rd_n && !ftdi_rxf_n;
        take = m_valid && m_ready;
        d    = m_data;
        @(posedge ftdiclk);
        #1;
        if (xfer) src_idx++;
        if (take) got.push_back(d);
        drive_src();
    endtask

    task automatic load(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) src[i] = base + 8'(i);
        src_idx = 0;
        src_len = len;
        gap     = 1'b0;
        got.delete();
        drive_src();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((src_idx < src_len || m_valid) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(src_idx < src_len || m_valid), 32'd0);
        tick();
        tick();
    endtask

    task automatic check_seq(input string tag, input logic [7:0] base, input int len);
        check({tag, "_len"}, 32'(got.size()), 32'(len));
        for (int i = 0; i < len; i++) check(tag, 32'(got[i]), 32'(base + 8'(i)));
    endtask

    initial begin
        reset     = 1'b1;
        rx_enable = 1'b0;
        m_ready   = 1'b0;
        drive_src();

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_oe_n", 32'(ftdi_oe_n), 32'd1);
        check("rst_rd_n", 32'(ftdi_rd_n), 32'd1);
        check("rst_active", 32'(rx_active), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);

        // Basic burst A1..A4 with oe_n leading rd_n by one cycle
        rx_enable = 1'b1;
        m_ready   = 1'b1;
        load(8'hA1, 4);
        tick();
        check("burst_turn_oe", 32'(ftdi_oe_n), 32'd0);
        check("burst_turn_rd", 32'(ftdi_rd_n), 32'd1);
        check("burst_turn_act", 32'(rx_active), 32'd1);
        tick();
        check("burst_read_rd", 32'(ftdi_rd_n), 32'd0);
        tick();
        check("burst_first_valid", 32'(m_valid), 32'd1);
        check("burst_first_data", 32'(m_data), 32'hA1);
        tick();
        tick();
        tick();
        check("burst_last_rd", 32'(ftdi_rd_n), 32'd0);
        tick();
        check("burst_exit_rd", 32'(ftdi_rd_n), 32'd1);
        check("burst_exit_oe", 32'(ftdi_oe_n), 32'd1);
        check("burst_exit_act", 32'(rx_active), 32'd0);
        drain("burst_drain");
        check_seq("burst_seq", 8'hA1, 4);

        // Backpressure: exactly DEPTH bytes captured, then all 20 delivered in order
        m_ready = 1'b0;
        load(8'h00, 20);
        for (int i = 0; i < 14; i++) tick();
        check("bp_count", 32'(fifo_count), 32'd8);
        check("bp_rd_n", 32'(ftdi_rd_n), 32'd1);
        check("bp_oe_n", 32'(ftdi_oe_n), 32'd1);
        check("bp_captured", 32'(src_idx), 32'd8);
        m_ready = 1'b1;
        drain("bp_drain");
        check_seq("bp_seq", 8'h00, 20);

        // FTDI gap after byte 0x05
        load(8'h00, 10);
        for (int n = 0; n < 50 && src_idx < 6; n++) tick();
        check("gap_reach", 32'(src_idx), 32'd6);
        gap = 1'b1;
        drive_src();
        tick();
        tick();
        tick();
        check("gap_no_push", 32'(src_idx), 32'd6);
        check("gap_rd_n", 32'(ftdi_rd_n), 32'd1);
        check("gap_active", 32'(rx_active), 32'd0);
        gap = 1'b0;
        drive_src();
        tick();
        check("gap_turn_oe", 32'(ftdi_oe_n), 32'd0);
        check("gap_turn_rd", 32'(ftdi_rd_n), 32'd1);
        drain("gap_drain");
        check_seq("gap_seq", 8'h00, 10);

        // Grant gating
        rx_enable = 1'b0;
        load(8'h30, 3);
        for (int i = 0; i < 4; i++) tick();
        check("grant_oe_n", 32'(ftdi_oe_n), 32'd1);
        check("grant_rd_n", 32'(ftdi_rd_n), 32'd1);
        check("grant_active", 32'(rx_active), 32'd0);
        check("grant_no_xfer", 32'(src_idx), 32'd0);
        rx_enable = 1'b1;
        tick();
        tick();
        tick();
        check("grant_first", 32'(src_idx), 32'd1);
        rx_enable = 1'b0;
        tick();
        check("grant_kept", 32'(src_idx), 32'd2);
        check("grant_drop_rd", 32'(ftdi_rd_n), 32'd1);
        check("grant_drop_oe", 32'(ftdi_oe_n), 32'd1);
        tick();
        tick();
        tick();
        check("grant_held_len", 32'(got.size()), 32'd2);
        rx_enable = 1'b1;
        drain("grant_drain");
        check_seq("grant_seq", 8'h30, 3);

        // Boundary: count at DEPTH-1 with simultaneous push and pop
        m_ready = 1'b0;
        load(8'h40, 16);
        for (int n = 0; n < 50 && fifo_count != 4'd7; n++) tick();
        check("bnd_reach", 32'(fifo_count), 32'd7);
        m_ready = 1'b1;
        tick();
        check("bnd_count", 32'(fifo_count), 32'd7);
        check("bnd_rd_n", 32'(ftdi_rd_n), 32'd0);
        tick();
        check("bnd_count2", 32'(fifo_count), 32'd7);
        check("bnd_rd_n2", 32'(ftdi_rd_n), 32'd0);
        drain("bnd_drain");
        check_seq("bnd_seq", 8'h40, 16);

        // Reset during READ with 3 bytes buffered
        m_ready = 1'b0;
        load(8'h50, 8);
        for (int n = 0; n < 50 && fifo_count != 4'd3; n++) tick();
        check("rr_reach", 32'(fifo_count), 32'd3);
        check("rr_in_read", 32'(ftdi_rd_n), 32'd0);
        reset = 1'b1;
        tick();
        check("rr_valid", 32'(m_valid), 32'd0);
        check("rr_count", 32'(fifo_count), 32'd0);
        check("rr_oe_n", 32'(ftdi_oe_n), 32'd1);
        check("rr_rd_n", 32'(ftdi_rd_n), 32'd1);
        check("rr_active", 32'(rx_active), 32'd0);
        reset   = 1'b0;
        m_ready = 1'b1;
        drain("rr_drain");
        check_seq("rr_seq", 8'h54, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ftdi_sync_rx.md
# ftdi_sync_rx

Receive-direction engine for the FT232H synchronous FIFO interface. It pulls host-to-device bytes out of the FTDI chip using the RXF#/OE#/RD# handshake on the 60 MHz `ftdiclk`. It buffers the bytes in an internal first-word-fall-through FIFO and presents them on a valid/ready byte stream to downstream logic. It sits next to the transmit path on the shared `ftdi_data` bus; the top level owns the tri-state, and this block only samples the bus.

## Interface

- `DEPTH`, 8: receive FIFO depth in bytes; power of two, minimum 4.
- `ftdiclk`  input  1  60 MHz clock from the FTDI; all logic is on its rising edge.
- `reset`  input  1  synchronous, active-high reset, in the `ftdiclk` domain.
- `ftdi_rxf_n`  input  1  FTDI receive-data-available, active low.
- `ftdi_data_in`  input  8  sampled value of the `ftdi_data` pins.
- `ftdi_oe_n`  output  1  FTDI output enable, active low, registered.
- `ftdi_rd_n`  output  1  FTDI read strobe, active low, registered.
- `rx_enable`  input  1  bus grant from the arbiter; 0 forbids starting or continuing a read.
- `rx_active`  output  1  high whenever state ≠ IDLE; the transmit path must not drive `ftdi_data` while this is high.
- `m_data`  output  8  head-of-FIFO byte.
- `m_valid`  output  1  FIFO not empty.
- `m_ready`  input  1  consumer accepts `m_data` this cycle.
- `fifo_count`  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

**Reset values**
- `ftdi_oe_n`=1, `ftdi_rd_n`=1, `rx_active`=0.
- `m_valid`=0, `fifo_count`=0; FIFO pointers cleared.
- State = IDLE.

**Transfer and FIFO rules**
- A byte transfers at a rising edge exactly when `ftdi_rd_n`==0 and `ftdi_rxf_n`==0 (as sampled at that edge). `ftdi_data_in` is pushed into the FIFO on that edge.
- Pop occurs on every edge where `m_valid`&&`m_ready`.
- Push and pop on the same edge leave `fifo_count` unchanged.
- `count_next` = count + push − pop.
- The FIFO never overflows. `ftdi_rd_n` may be low in the next cycle only if `count_next` ≤ DEPTH−1, i.e. there is at least one free slot for the next edge's possible push.

**State machine**
- **IDLE**: `oe_n`=1, `rd_n`=1.
  - Go to TURN when `rx_enable` && !`ftdi_rxf_n` && `count_next` ≤ DEPTH−1; `oe_n`<=0.
- **TURN**: one bus-turnaround cycle with `oe_n`=0, `rd_n`=1.
  - If the entry condition still holds, go to READ with `rd_n`<=0.
  - Otherwise go to IDLE with `oe_n`<=1.
- **READ**: `oe_n`=0, `rd_n`=0; push per the transfer rule.
  - Leave to IDLE when `ftdi_rxf_n`==1, or !`rx_enable`, or `count_next` == DEPTH. On exit `rd_n`<=1 and `oe_n`<=1 on the same edge.
  - A transfer on the exit edge still counts.
- `rx_enable` dropping has effect only at the next edge; the byte on the current edge is never lost.

## Timing

- `ftdi_rxf_n` low seen at edge k (IDLE, enabled, space available):
  - `oe_n` low after edge k;
  - `rd_n` low after edge k+1;
  - first byte captured at edge k+2;
  - `m_valid` high after edge k+2.
- Sustained throughput is 1 byte/clock while `rxf_n` stays low and the consumer keeps up.
- Re-entry after any exit costs at least 2 cycles: IDLE → TURN → READ.
- Backpressure: with `m_ready`=0 and an empty FIFO, exactly DEPTH bytes are captured, then `rd_n` rises on the edge that fills the FIFO.
- Reset asserted mid-READ: `oe_n`/`rd_n` are 1 after that edge and the FIFO contents are discarded. A byte presented on the reset edge is not pushed.

## Test plan

- **Basic burst**: `rxf_n` low for 4 data cycles with bytes 0xA1..0xA4, `m_ready`=1 → `m_data` sequence is A1, A2, A3, A4; `oe_n` leads `rd_n` by exactly 1 cycle; both rise on the edge after `rxf_n` goes high.
- **Backpressure**: DEPTH=8, source holds 20 bytes 0x00..0x13, `m_ready`=0 → exactly 8 bytes captured, `fifo_count`=8, `rd_n`=1. Then `m_ready`=1 → all 20 bytes delivered in order, with no duplicates or drops.
- **FTDI gap**: `rxf_n` high for 3 cycles mid-burst after byte 0x05 → no push during the gap. Re-entry goes through TURN, and the next byte delivered is 0x06.
- **Grant gating**: `rx_enable`=0 while `rxf_n`=0 → `oe_n`/`rd_n` stay 1 and `rx_active`=0. `rx_enable` dropped mid-READ → the byte on that edge is kept and `rd_n` rises after it.
- **Boundary**: FIFO at DEPTH−1 with simultaneous push and pop → `fifo_count` stays DEPTH−1, `rd_n` stays low, and order is preserved.
- **Reset mid-read**: reset pulsed during READ with 3 bytes buffered → `m_valid`=0, `fifo_count`=0, `oe_n`=`rd_n`=1 after the edge, and normal reads resume afterwards.
